// File: rtl/sdp_ram_burst_reader.sv
// Burst read master for a simple dual-port RAM: issues reads, hides the RAM latency, streams words out.
// Optional abort input is enabled by defining SDP_BURST_READER_ABORT_EN.
module sdp_ram_burst_reader #(
    parameter int  RAM_WIDTH       = 64,
    parameter int  RAM_DEPTH       = 512,
    parameter      RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter int  LEN_WIDTH       = 16,
    localparam int AW              = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clka,
    input  logic                 rst,
`ifdef SDP_BURST_READER_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [AW-1:0]        cmd_addr,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    output logic [AW-1:0]        ram_addrb,
    output logic                 ram_enb,
    output logic                 ram_regceb,
    output logic                 ram_rstb,
    input  logic [RAM_WIDTH-1:0] ram_doutb,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done
);
    localparam int LAT        = (RAM_PERFORMANCE == "LOW_LATENCY") ? 1 : 2;
    localparam int FIFO_DEPTH = LAT + 2;
    localparam int PW         = $clog2(FIFO_DEPTH);
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [LEN_WIDTH-1:0]   rem_q, rem_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic [LAT-1:0]         pipe_vld_q, pipe_vld_d;
    logic [LAT-1:0]         pipe_last_q, pipe_last_d;
    logic [RAM_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [RAM_WIDTH-1:0]   fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  fifo_last_q, fifo_last_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          fifo_count_q, fifo_count_d;

    logic [CW-1:0]          in_flight;
    logic [CW:0]            occupancy, capacity;
    logic                   issue, push, pop, room, abort_hit;

`ifdef SDP_BURST_READER_ABORT_EN
    assign abort_hit = abort && (state_q != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < LAT; i++) in_flight = in_flight + CW'(pipe_vld_q[i]);
    end

    // A slot freed by a same-cycle pop can be reused by this cycle's issue.
    assign pop       = (fifo_count_q != '0) && m_ready;
    assign push      = pipe_vld_q[LAT-1];
    assign occupancy = {1'b0, fifo_count_q} + {1'b0, in_flight};
    assign capacity  = (CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop};
    assign room      = occupancy < capacity;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_len;
                    state_d = (cmd_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (room) begin
                    issue  = 1'b1;
                    addr_d = (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + AW'(1);
                    rem_d  = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (in_flight == '0 && fifo_count_q == '0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_hit) begin
            issue   = 1'b0;
            addr_d  = addr_q;
            rem_d   = rem_q;
            state_d = (state_q == DONE) ? IDLE : DONE;
        end
        cmd_ready_d = (state_d == IDLE);
    end

    // The last flag travels with the read so m_last never depends on counters downstream.
    always_comb begin
        pipe_vld_d     = pipe_vld_q;
        pipe_last_d    = pipe_last_q;
        pipe_vld_d[0]  = issue;
        pipe_last_d[0] = issue && (rem_q == LEN_WIDTH'(1));
        for (int i = 1; i < LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_last_d[i] = pipe_last_q[i-1];
        end
        if (abort_hit) begin
            pipe_vld_d  = '0;
            pipe_last_d = '0;
        end
    end

    always_comb begin
        fifo_data_d  = fifo_data_q;
        fifo_last_d  = fifo_last_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
        if (push) begin
            fifo_data_d[wr_ptr_q] = ram_doutb;
            fifo_last_d[wr_ptr_q] = pipe_last_q[LAT-1];
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        if (abort_hit) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fifo_count_d = '0;
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            cmd_ready_q  <= 1'b0;
            pipe_vld_q   <= '0;
            pipe_last_q  <= '0;
            fifo_last_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            cmd_ready_q  <= cmd_ready_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_last_q  <= pipe_last_d;
            fifo_last_q  <= fifo_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            fifo_data_q  <= fifo_data_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign ram_addrb  = addr_q;
    assign ram_enb    = issue;
    assign ram_regceb = 1'b1;
    assign ram_rstb   = abort_hit;
    assign m_valid    = (fifo_count_q != '0);
    assign m_data     = fifo_data_q[rd_ptr_q];
    assign m_last     = m_valid && fifo_last_q[rd_ptr_q];
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule
